// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding muxes, ALU, destination
// select and the EX/MEM pipeline register (with halt freeze and flush bubble).
module execute_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_OP   = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_shamt,
    input  logic [NB_DATA-1:0] i_pc_plus8,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_OP-1:0]   i_ctl_EX_alu_op,
    input  logic               i_ctl_EX_alu_src,
    input  logic [1:0]         i_ctl_EX_reg_dst,
    input  logic               i_ctl_EX_link,
    input  logic [1:0]         i_fwd_a,
    input  logic [1:0]         i_fwd_b,
    input  logic [NB_DATA-1:0] i_fwd_mem_data,
    input  logic [NB_DATA-1:0] i_fwd_wb_data,
    input  logic               i_ctl_MEM_mem_read,
    input  logic               i_ctl_MEM_mem_write,
    input  logic               i_ctl_MEM_unsigned,
    input  logic [1:0]         i_ctl_MEM_data_width,
    input  logic               i_ctl_WB_mem_to_reg,
    input  logic               i_ctl_WB_reg_write,
    output logic [NB_DATA-1:0] o_ALU_result,
    output logic [NB_DATA-1:0] o_data_to_write,
    output logic [NB_REG-1:0]  o_reg_dest,
    output logic               o_ctl_MEM_mem_read,
    output logic               o_ctl_MEM_mem_write,
    output logic               o_ctl_MEM_unsigned,
    output logic [1:0]         o_ctl_MEM_data_width,
    output logic               o_ctl_WB_mem_to_reg,
    output logic               o_ctl_WB_reg_write
);

    localparam logic [NB_OP-1:0] OP_ADDU  = 4'd0;
    localparam logic [NB_OP-1:0] OP_SUBU  = 4'd1;
    localparam logic [NB_OP-1:0] OP_AND   = 4'd2;
    localparam logic [NB_OP-1:0] OP_OR    = 4'd3;
    localparam logic [NB_OP-1:0] OP_XOR   = 4'd4;
    localparam logic [NB_OP-1:0] OP_NOR   = 4'd5;
    localparam logic [NB_OP-1:0] OP_SLT   = 4'd6;
    localparam logic [NB_OP-1:0] OP_SLTU  = 4'd7;
    localparam logic [NB_OP-1:0] OP_SLL   = 4'd8;
    localparam logic [NB_OP-1:0] OP_SRL   = 4'd9;
    localparam logic [NB_OP-1:0] OP_SRA   = 4'd10;
    localparam logic [NB_OP-1:0] OP_SLLV  = 4'd11;
    localparam logic [NB_OP-1:0] OP_SRLV  = 4'd12;
    localparam logic [NB_OP-1:0] OP_SRAV  = 4'd13;
    localparam logic [NB_OP-1:0] OP_LUI   = 4'd14;

    localparam int HALF = NB_DATA / 2;

    logic [NB_DATA-1:0] op_a;
    logic [NB_DATA-1:0] rt_fwd;
    logic [NB_DATA-1:0] op_b;
    logic [NB_REG-1:0]  var_shamt;
    logic [NB_DATA-1:0] alu_res;
    logic [NB_DATA-1:0] result;
    logic [NB_REG-1:0]  reg_dest;

    // Selector 11 falls back to the ID/EX value; conflict resolution lives in the hazard unit.
    always_comb begin
        case (i_fwd_a)
            2'b01:   op_a = i_fwd_mem_data;
            2'b10:   op_a = i_fwd_wb_data;
            default: op_a = i_rs_data;
        endcase
        case (i_fwd_b)
            2'b01:   rt_fwd = i_fwd_mem_data;
            2'b10:   rt_fwd = i_fwd_wb_data;
            default: rt_fwd = i_rt_data;
        endcase
        op_b = i_ctl_EX_alu_src ? i_imm : rt_fwd;
    end

    assign var_shamt = op_a[NB_REG-1:0];

    always_comb begin
        case (i_ctl_EX_alu_op)
            OP_ADDU: alu_res = op_a + op_b;
            OP_SUBU: alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, (op_a < op_b)};
            OP_SLL:  alu_res = op_b << i_shamt;
            OP_SRL:  alu_res = op_b >> i_shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> i_shamt;
            OP_SLLV: alu_res = op_b << var_shamt;
            OP_SRLV: alu_res = op_b >> var_shamt;
            OP_SRAV: alu_res = $signed(op_b) >>> var_shamt;
            OP_LUI:  alu_res = {op_b[HALF-1:0], {HALF{1'b0}}};
            default: alu_res = op_a;
        endcase
    end

    assign result = i_ctl_EX_link ? i_pc_plus8 : alu_res;

    always_comb begin
        case (i_ctl_EX_reg_dst)
            2'b00:   reg_dest = i_rt;
            2'b01:   reg_dest = i_rd;
            2'b10:   reg_dest = {NB_REG{1'b1}};
            default: reg_dest = '0;
        endcase
    end

    // EX/MEM register: halt freezes everything, flush loads an all-zero bubble.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ALU_result         <= '0;
            o_data_to_write      <= '0;
            o_reg_dest           <= '0;
            o_ctl_MEM_mem_read   <= 1'b0;
            o_ctl_MEM_mem_write  <= 1'b0;
            o_ctl_MEM_unsigned   <= 1'b0;
            o_ctl_MEM_data_width <= 2'b00;
            o_ctl_WB_mem_to_reg  <= 1'b0;
            o_ctl_WB_reg_write   <= 1'b0;
        end else if (!i_halt) begin
            if (i_flush) begin
                o_ALU_result         <= '0;
                o_data_to_write      <= '0;
                o_reg_dest           <= '0;
                o_ctl_MEM_mem_read   <= 1'b0;
                o_ctl_MEM_mem_write  <= 1'b0;
                o_ctl_MEM_unsigned   <= 1'b0;
                o_ctl_MEM_data_width <= 2'b00;
                o_ctl_WB_mem_to_reg  <= 1'b0;
                o_ctl_WB_reg_write   <= 1'b0;
            end else begin
                o_ALU_result         <= result;
                o_data_to_write      <= rt_fwd;
                o_reg_dest           <= reg_dest;
                o_ctl_MEM_mem_read   <= i_ctl_MEM_mem_read;
                o_ctl_MEM_mem_write  <= i_ctl_MEM_mem_write;
                o_ctl_MEM_unsigned   <= i_ctl_MEM_unsigned;
                o_ctl_MEM_data_width <= i_ctl_MEM_data_width;
                o_ctl_WB_mem_to_reg  <= i_ctl_WB_mem_to_reg;
                o_ctl_WB_reg_write   <= i_ctl_WB_reg_write;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed + random stimulus, expected outputs queued from a
// behavioural model and popped by an independent monitor after every clock edge.
module tb_execute_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_halt;
    logic        i_flush;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic [31:0] i_imm;
    logic [4:0]  i_shamt;
    logic [31:0] i_pc_plus8;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [3:0]  i_ctl_EX_alu_op;
    logic        i_ctl_EX_alu_src;
    logic [1:0]  i_ctl_EX_reg_dst;
    logic        i_ctl_EX_link;
    logic [1:0]  i_fwd_a;
    logic [1:0]  i_fwd_b;
    logic [31:0] i_fwd_mem_data;
    logic [31:0] i_fwd_wb_data;
    logic        i_ctl_MEM_mem_read;
    logic        i_ctl_MEM_mem_write;
    logic        i_ctl_MEM_unsigned;
    logic [1:0]  i_ctl_MEM_data_width;
    logic        i_ctl_WB_mem_to_reg;
    logic        i_ctl_WB_reg_write;
    logic [31:0] o_ALU_result;
    logic [31:0] o_data_to_write;
    logic [4:0]  o_reg_dest;
    logic        o_ctl_MEM_mem_read;
    logic        o_ctl_MEM_mem_write;
    logic        o_ctl_MEM_unsigned;
    logic [1:0]  o_ctl_MEM_data_width;
    logic        o_ctl_WB_mem_to_reg;
    logic        o_ctl_WB_reg_write;

    execute_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt), .i_flush(i_flush),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt),
        .i_pc_plus8(i_pc_plus8), .i_rt(i_rt), .i_rd(i_rd),
        .i_ctl_EX_alu_op(i_ctl_EX_alu_op), .i_ctl_EX_alu_src(i_ctl_EX_alu_src),
        .i_ctl_EX_reg_dst(i_ctl_EX_reg_dst), .i_ctl_EX_link(i_ctl_EX_link),
        .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
        .i_fwd_mem_data(i_fwd_mem_data), .i_fwd_wb_data(i_fwd_wb_data),
        .i_ctl_MEM_mem_read(i_ctl_MEM_mem_read), .i_ctl_MEM_mem_write(i_ctl_MEM_mem_write),
        .i_ctl_MEM_unsigned(i_ctl_MEM_unsigned), .i_ctl_MEM_data_width(i_ctl_MEM_data_width),
        .i_ctl_WB_mem_to_reg(i_ctl_WB_mem_to_reg), .i_ctl_WB_reg_write(i_ctl_WB_reg_write),
        .o_ALU_result(o_ALU_result), .o_data_to_write(o_data_to_write),
        .o_reg_dest(o_reg_dest),
        .o_ctl_MEM_mem_read(o_ctl_MEM_mem_read), .o_ctl_MEM_mem_write(o_ctl_MEM_mem_write),
        .o_ctl_MEM_unsigned(o_ctl_MEM_unsigned), .o_ctl_MEM_data_width(o_ctl_MEM_data_width),
        .o_ctl_WB_mem_to_reg(o_ctl_WB_mem_to_reg), .o_ctl_WB_reg_write(o_ctl_WB_reg_write)
    );

    // Outputs packed as {result, store, dest, mem_read, mem_write, unsigned, width, mem_to_reg, reg_write}
    logic [75:0] dut_out;
    assign dut_out = {o_ALU_result, o_data_to_write, o_reg_dest, o_ctl_MEM_mem_read,
                      o_ctl_MEM_mem_write, o_ctl_MEM_unsigned, o_ctl_MEM_data_width,
                      o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write};

    logic [75:0] exp_q[$];
    string       name_q[$];
    logic [75:0] model_last;
    int          n_checks;
    int          n_pass;

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] shift_steps(input logic [31:0] v, input int n,
                                                input bit right, input bit arith);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            if (right) r = {(arith ? r[31] : 1'b0), r[31:1]};
            else       r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh);
        logic [32:0]        wide;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            0: begin wide = {1'b0, a} + {1'b0, b}; return wide[31:0]; end
            1: return a + (~b) + 32'd1;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return (sa < sb) ? 32'd1 : 32'd0;
            7: return (a < b) ? 32'd1 : 32'd0;
            8: return shift_steps(b, sh, 1'b0, 1'b0);
            9: return shift_steps(b, sh, 1'b1, 1'b0);
            10: return shift_steps(b, sh, 1'b1, 1'b1);
            11: return shift_steps(b, int'(a[4:0]), 1'b0, 1'b0);
            12: return shift_steps(b, int'(a[4:0]), 1'b1, 1'b0);
            13: return shift_steps(b, int'(a[4:0]), 1'b1, 1'b1);
            14: return {b[15:0], 16'h0000};
            default: return a;
        endcase
    endfunction

    function automatic logic [75:0] ref_next();
        logic [31:0] src[4];
        logic [31:0] a;
        logic [31:0] st;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  dst[4];
        src = '{i_rs_data, i_fwd_mem_data, i_fwd_wb_data, i_rs_data};
        a   = src[i_fwd_a];
        src = '{i_rt_data, i_fwd_mem_data, i_fwd_wb_data, i_rt_data};
        st  = src[i_fwd_b];
        b   = i_ctl_EX_alu_src ? i_imm : st;
        res = i_ctl_EX_link ? i_pc_plus8 : ref_alu(int'(i_ctl_EX_alu_op), a, b, int'(i_shamt));
        dst = '{i_rt, i_rd, 5'd31, 5'd0};
        return {res, st, dst[i_ctl_EX_reg_dst], i_ctl_MEM_mem_read, i_ctl_MEM_mem_write,
                i_ctl_MEM_unsigned, i_ctl_MEM_data_width, i_ctl_WB_mem_to_reg,
                i_ctl_WB_reg_write};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string nm, input logic [75:0] act, input logic [75:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_defaults();
        i_halt = 0; i_flush = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0; i_pc_plus8 = 0;
        i_rt = 0; i_rd = 0; i_ctl_EX_alu_op = 0; i_ctl_EX_alu_src = 0;
        i_ctl_EX_reg_dst = 0; i_ctl_EX_link = 0; i_fwd_a = 0; i_fwd_b = 0;
        i_fwd_mem_data = 0; i_fwd_wb_data = 0;
        i_ctl_MEM_mem_read = 0; i_ctl_MEM_mem_write = 0; i_ctl_MEM_unsigned = 0;
        i_ctl_MEM_data_width = 0; i_ctl_WB_mem_to_reg = 0; i_ctl_WB_reg_write = 0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs(input bit allow_halt_flush);
        i_rs_data = rand_word(); i_rt_data = rand_word(); i_imm = rand_word();
        i_shamt = 5'($urandom); i_pc_plus8 = $urandom;
        i_rt = 5'($urandom); i_rd = 5'($urandom);
        i_ctl_EX_alu_op = 4'($urandom); i_ctl_EX_alu_src = 1'($urandom);
        i_ctl_EX_reg_dst = 2'($urandom); i_ctl_EX_link = ($urandom_range(0, 7) == 0);
        i_fwd_a = 2'($urandom); i_fwd_b = 2'($urandom);
        i_fwd_mem_data = rand_word(); i_fwd_wb_data = rand_word();
        i_ctl_MEM_mem_read = 1'($urandom); i_ctl_MEM_mem_write = 1'($urandom);
        i_ctl_MEM_unsigned = 1'($urandom); i_ctl_MEM_data_width = 2'($urandom);
        i_ctl_WB_mem_to_reg = 1'($urandom); i_ctl_WB_reg_write = 1'($urandom);
        i_halt  = allow_halt_flush && ($urandom_range(0, 9) == 0);
        i_flush = allow_halt_flush && ($urandom_range(0, 9) == 0);
    endtask

    // Called with inputs settled before a rising edge; queues the post-edge expectation.
    task automatic issue(input string nm);
        logic [75:0] nxt;
        if (i_halt)       nxt = model_last;
        else if (i_flush) nxt = '0;
        else              nxt = ref_next();
        model_last = nxt;
        exp_q.push_back(nxt);
        name_q.push_back(nm);
        @(negedge i_clk);
    endtask

    // ---------------- monitor ----------------
    always @(posedge i_clk) begin
        #1;
        if (!i_reset && exp_q.size() > 0) begin
            check(name_q.pop_front(), dut_out, exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        model_last = '0;
        set_defaults();
        i_reset = 1'b1;
        #2;
        check("reset_initial", dut_out, 76'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // ADDU wraps to 0x80000000, destination rd
        i_rs_data = 32'h7FFF_FFFF; i_rt_data = 32'd1; i_ctl_EX_reg_dst = 2'b01; i_rd = 5'd8;
        i_ctl_WB_reg_write = 1'b1;
        issue("addu_wrap");

        // Asynchronous reset between edges
        #2;
        i_reset = 1'b1;
        #1;
        check("reset_async", dut_out, 76'd0);
        model_last = '0;
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);

        set_defaults();
        i_rs_data = 32'hFFFF_FFFF; i_rt_data = 32'd1; i_ctl_EX_alu_op = 4'd6;
        issue("slt_signed");
        i_ctl_EX_alu_op = 4'd7;
        issue("sltu_unsigned");

        set_defaults();
        i_rt_data = 32'h8000_0000; i_shamt = 5'd4; i_ctl_EX_alu_op = 4'd10;
        issue("sra_shamt4");
        i_rs_data = 32'd36; i_ctl_EX_alu_op = 4'd12;
        issue("srlv_a36");

        set_defaults();
        i_fwd_a = 2'b01; i_fwd_mem_data = 32'h100; i_fwd_b = 2'b10; i_fwd_wb_data = 32'hAB;
        i_ctl_EX_alu_src = 1'b1; i_imm = 32'd4; i_ctl_MEM_mem_write = 1'b1;
        i_ctl_MEM_data_width = 2'b11;
        issue("fwd_store");

        // Halt freezes for 3 cycles while inputs change, then halt+flush still frozen
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(1'b0);
            i_halt = 1'b1;
            issue("halt_hold");
        end
        randomize_inputs(1'b0);
        i_halt = 1'b1; i_flush = 1'b1;
        issue("halt_flush_hold");

        randomize_inputs(1'b0);
        i_ctl_WB_reg_write = 1'b1; i_ctl_MEM_mem_write = 1'b1;
        i_flush = 1'b1;
        issue("flush_bubble");

        set_defaults();
        i_ctl_EX_link = 1'b1; i_ctl_EX_reg_dst = 2'b10; i_pc_plus8 = 32'h40;
        i_ctl_EX_alu_op = 4'd3; i_rs_data = 32'h1234; i_ctl_WB_reg_write = 1'b1;
        issue("jal_link");

        // Every opcode once with random operands, then fully random traffic
        for (int op = 0; op < 16; op++) begin
            randomize_inputs(1'b0);
            i_ctl_EX_link = 1'b0;
            i_ctl_EX_alu_op = 4'(op);
            issue($sformatf("op_sweep_%0d", op));
        end
        for (int i = 0; i < 300; i++) begin
            randomize_inputs(1'b1);
            issue("random");
        end

        set_defaults();
        i_halt = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge i_clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
